// File: rtl/rvv_backend_dispatch_operand_bypass.sv
// Single-entry dispatch hold stage: holds one uop against the ROB RAW comparator, stalls on
// outstanding writers, forwards the youngest matching ROB result per operand and issues it.
module rvv_backend_dispatch_operand_bypass #(
  parameter int ROB_DEPTH = 8,
  parameter int VLEN      = 128,
  parameter int PTR_W     = $clog2(ROB_DEPTH),
  parameter int STALL_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uop_valid,
  output logic                      uop_ready,
  input  logic [4:0]                uop_vs1_idx,
  input  logic [4:0]                uop_vs2_idx,
  input  logic                      uop_vs1_vld,
  input  logic                      uop_vs2_vld,
  input  logic                      uop_vm,
  output logic [4:0]                hold_vs1_idx,
  output logic [4:0]                hold_vs2_idx,
  output logic                      hold_vs1_vld,
  output logic                      hold_vs2_vld,
  output logic                      hold_vm,
  input  logic [ROB_DEPTH-1:0]      vs1_hit,
  input  logic [ROB_DEPTH-1:0]      vs2_hit,
  input  logic [ROB_DEPTH-1:0]      v0_hit,
  input  logic                      vs1_wait,
  input  logic                      vs2_wait,
  input  logic                      v0_wait,
  input  logic [PTR_W-1:0]          rob_head,
  input  logic [ROB_DEPTH*VLEN-1:0] rob_w_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_vs1_fwd,
  output logic                      out_vs2_fwd,
  output logic                      out_v0_fwd,
  output logic [VLEN-1:0]           out_vs1_data,
  output logic [VLEN-1:0]           out_vs2_data,
  output logic [VLEN-1:0]           out_v0_data,
  output logic [STALL_W-1:0]        stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [4:0]         held_vs1_idx, held_vs2_idx;
  logic               held_vs1_vld, held_vs2_vld, held_vm;
  logic [STALL_W-1:0] stall_cnt;
  logic               capture, load, any_wait, retire;

  logic [PTR_W:0]     vs1_pick, vs2_pick, v0_pick;
  logic [VLEN-1:0]    vs1_sel_data, vs2_sel_data, v0_sel_data;

  // Returns {found, index} of the hit entry furthest from the head, i.e. the youngest writer.
  function automatic logic [PTR_W:0] pick_youngest(input logic [ROB_DEPTH-1:0] hit,
                                                   input logic [PTR_W-1:0]     head);
    logic             found;
    logic [PTR_W-1:0] best, best_age, age;
    found    = 1'b0;
    best     = '0;
    best_age = '0;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      age = PTR_W'(i) - head;
      if (hit[i] && (!found || age > best_age)) begin
        found    = 1'b1;
        best     = PTR_W'(i);
        best_age = age;
      end
    end
    return {found, best};
  endfunction

  function automatic logic [VLEN-1:0] entry_data(input logic [PTR_W:0]          sel,
                                                 input logic [ROB_DEPTH*VLEN-1:0] data);
    logic [VLEN-1:0] d;
    d = '0;
    if (sel[PTR_W]) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        if (PTR_W'(i) == sel[PTR_W-1:0]) d = data[i*VLEN +: VLEN];
      end
    end
    return d;
  endfunction

  always_comb begin
    vs1_pick     = pick_youngest(vs1_hit, rob_head);
    vs2_pick     = pick_youngest(vs2_hit, rob_head);
    v0_pick      = pick_youngest(v0_hit, rob_head);
    vs1_sel_data = entry_data(vs1_pick, rob_w_data);
    vs2_sel_data = entry_data(vs2_pick, rob_w_data);
    v0_sel_data  = entry_data(v0_pick, rob_w_data);
  end

  assign any_wait  = vs1_wait | vs2_wait | v0_wait;
  assign retire    = (state == ISSUE) & out_ready;
  assign uop_ready = (state == EMPTY) | retire;

  // Comparator sees a harmless request (no sources, unmasked) while the stage is empty.
  assign hold_vs1_idx = held_vs1_idx;
  assign hold_vs2_idx = held_vs2_idx;
  assign hold_vs1_vld = (state != EMPTY) & held_vs1_vld;
  assign hold_vs2_vld = (state != EMPTY) & held_vs2_vld;
  assign hold_vm      = (state == EMPTY) | held_vm;
  assign stall_cycles = stall_cnt;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (uop_valid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!any_wait) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          capture   = uop_valid;
          state_nxt = uop_valid ? HOLD : EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      capture   = 1'b0;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      held_vs1_idx <= '0;
      held_vs2_idx <= '0;
      held_vs1_vld <= 1'b0;
      held_vs2_vld <= 1'b0;
      held_vm      <= 1'b1;
      stall_cnt    <= '0;
      out_valid    <= 1'b0;
      out_vs1_fwd  <= 1'b0;
      out_vs2_fwd  <= 1'b0;
      out_v0_fwd   <= 1'b0;
      out_vs1_data <= '0;
      out_vs2_data <= '0;
      out_v0_data  <= '0;
    end else begin
      state <= state_nxt;

      if (capture) begin
        held_vs1_idx <= uop_vs1_idx;
        held_vs2_idx <= uop_vs2_idx;
        held_vs1_vld <= uop_vs1_vld;
        held_vs2_vld <= uop_vs2_vld;
        held_vm      <= uop_vm;
      end

      if (capture || flush) begin
        stall_cnt <= '0;
      end else if (state == HOLD && any_wait && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
      end else if (retire) begin
        out_valid <= 1'b0;
      end

      if (load) begin
        out_vs1_fwd  <= vs1_pick[PTR_W];
        out_vs2_fwd  <= vs2_pick[PTR_W];
        out_v0_fwd   <= v0_pick[PTR_W];
        out_vs1_data <= vs1_sel_data;
        out_vs2_data <= vs2_sel_data;
        out_v0_data  <= v0_sel_data;
      end
    end
  end

endmodule

// File: tb/tb_rvv_backend_dispatch_operand_bypass.sv
// Self-checking bench for the dispatch operand bypass stage: random ROB contents and hit
// patterns checked against an age-based youngest-writer model and cycle-level latency rules.
module tb_rvv_backend_dispatch_operand_bypass;

  localparam int D = 8;
  localparam int VLEN = 128;
  localparam int PTR_W = 3;
  localparam int STALL_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic uop_valid, uop_ready;
  logic [4:0] uop_vs1_idx, uop_vs2_idx;
  logic uop_vs1_vld, uop_vs2_vld, uop_vm;
  logic [4:0] hold_vs1_idx, hold_vs2_idx;
  logic hold_vs1_vld, hold_vs2_vld, hold_vm;
  logic [D-1:0] vs1_hit, vs2_hit, v0_hit;
  logic vs1_wait, vs2_wait, v0_wait;
  logic [PTR_W-1:0] rob_head;
  logic [D*VLEN-1:0] rob_w_data;
  logic flush;
  logic out_valid, out_ready;
  logic out_vs1_fwd, out_vs2_fwd, out_v0_fwd;
  logic [VLEN-1:0] out_vs1_data, out_vs2_data, out_v0_data;
  logic [STALL_W-1:0] stall_cycles;

  logic [VLEN-1:0] rob_data [D];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    rob_w_data = '0;
    for (int i = 0; i < D; i++) rob_w_data[i*VLEN +: VLEN] = rob_data[i];
  end

  rvv_backend_dispatch_operand_bypass #(
    .ROB_DEPTH(D), .VLEN(VLEN), .PTR_W(PTR_W), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst(rst),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_vs1_idx(uop_vs1_idx), .uop_vs2_idx(uop_vs2_idx),
    .uop_vs1_vld(uop_vs1_vld), .uop_vs2_vld(uop_vs2_vld), .uop_vm(uop_vm),
    .hold_vs1_idx(hold_vs1_idx), .hold_vs2_idx(hold_vs2_idx),
    .hold_vs1_vld(hold_vs1_vld), .hold_vs2_vld(hold_vs2_vld), .hold_vm(hold_vm),
    .vs1_hit(vs1_hit), .vs2_hit(vs2_hit), .v0_hit(v0_hit),
    .vs1_wait(vs1_wait), .vs2_wait(vs2_wait), .v0_wait(v0_wait),
    .rob_head(rob_head), .rob_w_data(rob_w_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vs1_fwd(out_vs1_fwd), .out_vs2_fwd(out_vs2_fwd), .out_v0_fwd(out_v0_fwd),
    .out_vs1_data(out_vs1_data), .out_vs2_data(out_vs2_data), .out_v0_data(out_v0_data),
    .stall_cycles(stall_cycles)
  );

  // Reference: youngest writer = hit entry with the largest distance from the ROB head.
  function automatic int model_pick(input logic [D-1:0] hit, input int head);
    int best = -1;
    int best_age = -1;
    for (int i = 0; i < D; i++) begin
      int age = (i - head + D) % D;
      if (hit[i] && age > best_age) begin
        best = i;
        best_age = age;
      end
    end
    return best;
  endfunction

  function automatic logic [VLEN-1:0] model_data(input int idx);
    if (idx < 0) return '0;
    return rob_data[idx];
  endfunction

  function automatic logic [VLEN-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    uop_valid = 0; uop_vs1_idx = 0; uop_vs2_idx = 0;
    uop_vs1_vld = 0; uop_vs2_vld = 0; uop_vm = 1;
    vs1_hit = 0; vs2_hit = 0; v0_hit = 0;
    vs1_wait = 0; vs2_wait = 0; v0_wait = 0;
    rob_head = 0; flush = 0; out_ready = 0;
  endtask

  task automatic randomize_rob();
    for (int i = 0; i < D; i++) rob_data[i] = rand_vec();
  endtask

  // Offers the prepared uop from EMPTY, holds vs2_wait for nwait HOLD cycles, then waits
  // (bounded) for out_valid. lat counts clock edges from the capture edge inclusive.
  task automatic offer(input int nwait, output int lat);
    uop_valid = 1;
    vs2_wait = (nwait > 0);
    step();
    uop_valid = 0;
    lat = 1;
    for (int j = 0; j < nwait; j++) begin
      step();
      lat++;
    end
    vs2_wait = 0;
    while (!out_valid && lat < nwait + 20) begin
      step();
      lat++;
    end
  endtask

  task automatic retire_uop();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || stall_cycles !== '0 || hold_vs1_vld !== 1'b0 ||
        hold_vs2_vld !== 1'b0 || hold_vm !== 1'b1 || uop_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl: out_valid=%b stall=%0d hvld=%b%b hvm=%b ready=%b required 0 0 00 1 1",
               out_valid, stall_cycles, hold_vs1_vld, hold_vs2_vld, hold_vm, uop_ready);
    end
    checks++;
    if ({out_vs1_fwd, out_vs2_fwd, out_v0_fwd} !== 3'b000 ||
        (out_vs1_data | out_vs2_data | out_v0_data) !== '0) begin
      failures++;
      $display("FAIL reset_payload: fwd=%b%b%b data_or=%h required 000 and zero",
               out_vs1_fwd, out_vs2_fwd, out_v0_fwd, out_vs1_data | out_vs2_data | out_v0_data);
    end
  endtask

  task automatic test_no_hazard();
    int lat;
    randomize_rob();
    uop_vs1_idx = 3; uop_vs2_idx = 4; uop_vs1_vld = 1; uop_vs2_vld = 1; uop_vm = 1;
    uop_valid = 1;
    step();
    uop_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || hold_vs1_idx !== 5'd3 || hold_vs2_idx !== 5'd4 ||
        hold_vs1_vld !== 1'b1 || hold_vs2_vld !== 1'b1 || hold_vm !== 1'b1 || uop_ready !== 1'b0) begin
      failures++;
      $display("FAIL nohaz_hold: ov=%b idx=%0d/%0d vld=%b%b vm=%b ready=%b required 0 3/4 11 1 0",
               out_valid, hold_vs1_idx, hold_vs2_idx, hold_vs1_vld, hold_vs2_vld, hold_vm, uop_ready);
    end
    step();
    lat = 2;
    checks++;
    if (out_valid !== 1'b1 || {out_vs1_fwd, out_vs2_fwd, out_v0_fwd} !== 3'b000 ||
        out_vs1_data !== '0 || stall_cycles !== '0) begin
      failures++;
      $display("FAIL nohaz_issue: lat=%0d ov=%b fwd=%b%b%b stall=%0d required ov=1 fwd=000 stall=0",
               lat, out_valid, out_vs1_fwd, out_vs2_fwd, out_v0_fwd, stall_cycles);
    end
    retire_uop();
    checks++;
    if (out_valid !== 1'b0 || uop_ready !== 1'b1 || hold_vs1_vld !== 1'b0) begin
      failures++;
      $display("FAIL nohaz_retire: ov=%b ready=%b hvld=%b required 0 1 0", out_valid, uop_ready, hold_vs1_vld);
    end
  endtask

  task automatic test_youngest_select();
    int lat, e1, e2, e0;
    for (int it = 0; it < 12; it++) begin
      randomize_rob();
      if (it == 0) begin
        rob_head = 6; vs1_hit = 8'b1000_0010; vs2_hit = 0; v0_hit = 0;
      end else begin
        rob_head = PTR_W'($urandom_range(0, D-1));
        vs1_hit = D'($urandom); vs2_hit = D'($urandom); v0_hit = D'($urandom);
      end
      uop_vs1_idx = 5'($urandom); uop_vs2_idx = 5'($urandom);
      uop_vs1_vld = 1; uop_vs2_vld = 1; uop_vm = 1'($urandom);
      e1 = model_pick(vs1_hit, int'(rob_head));
      e2 = model_pick(vs2_hit, int'(rob_head));
      e0 = model_pick(v0_hit, int'(rob_head));
      offer(0, lat);
      checks++;
      if (lat !== 2 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL sel_latency[%0d]: lat=%0d ov=%b required 2 1", it, lat, out_valid);
      end
      checks++;
      if (out_vs1_fwd !== (e1 >= 0) || out_vs1_data !== model_data(e1) ||
          out_vs2_fwd !== (e2 >= 0) || out_vs2_data !== model_data(e2) ||
          out_v0_fwd !== (e0 >= 0) || out_v0_data !== model_data(e0)) begin
        failures++;
        $display("FAIL sel_payload[%0d]: head=%0d fwd=%b%b%b required entries %0d %0d %0d vs1_data=%h exp=%h",
                 it, rob_head, out_vs1_fwd, out_vs2_fwd, out_v0_fwd, e1, e2, e0,
                 out_vs1_data, model_data(e1));
      end
      retire_uop();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    int lat, e2;
    int nw [4] = '{5, 1, 13, 300};
    for (int k = 0; k < 4; k++) begin
      randomize_rob();
      rob_head = PTR_W'($urandom_range(0, D-1));
      vs2_hit = D'(1) << $urandom_range(0, D-1);
      vs1_hit = 0; v0_hit = 0;
      uop_vs1_vld = 0; uop_vs2_vld = 1; uop_vs2_idx = 5'($urandom); uop_vm = 1;
      e2 = model_pick(vs2_hit, int'(rob_head));
      offer(nw[k], lat);
      checks++;
      if (lat !== nw[k] + 2 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_latency[%0d]: lat=%0d ov=%b required %0d 1", k, lat, out_valid, nw[k] + 2);
      end
      checks++;
      if (int'(stall_cycles) !== ((nw[k] > 255) ? 255 : nw[k]) ||
          out_vs2_fwd !== 1'b1 || out_vs2_data !== model_data(e2)) begin
        failures++;
        $display("FAIL stall_payload[%0d]: stall=%0d fwd=%b data=%h required %0d 1 %h",
                 k, stall_cycles, out_vs2_fwd, out_vs2_data,
                 (nw[k] > 255) ? 255 : nw[k], model_data(e2));
      end
      retire_uop();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int lat, e1, e0b;
    logic [VLEN-1:0] exp1;
    randomize_rob();
    rob_head = 2; vs1_hit = D'($urandom) | 8'h01;
    e1 = model_pick(vs1_hit, 2);
    exp1 = model_data(e1);
    uop_vs1_idx = 7; uop_vs1_vld = 1; uop_vm = 1;
    offer(0, lat);
    for (int c = 0; c < 3; c++) begin
      vs1_hit = D'($urandom);
      rob_head = PTR_W'($urandom);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_vs1_fwd !== 1'b1 || out_vs1_data !== exp1 || uop_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_stable[%0d]: ov=%b fwd=%b data=%h ready=%b required 1 1 %h 0",
                 c, out_valid, out_vs1_fwd, out_vs1_data, uop_ready, exp1);
      end
    end
    vs1_hit = 0; rob_head = 5; v0_hit = 8'b0100_0001;
    e0b = model_pick(v0_hit, 5);
    uop_vs1_idx = 9; uop_vm = 0; uop_valid = 1; out_ready = 1;
    #1;
    checks++;
    if (uop_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: uop_ready=%b required 1", uop_ready);
    end
    step();
    uop_valid = 0; out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || hold_vs1_idx !== 5'd9 || hold_vm !== 1'b0) begin
      failures++;
      $display("FAIL b2b_capture: ov=%b idx=%0d vm=%b required 0 9 0", out_valid, hold_vs1_idx, hold_vm);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_vs1_fwd !== 1'b0 || out_v0_fwd !== 1'b1 || out_v0_data !== model_data(e0b)) begin
      failures++;
      $display("FAIL b2b_issue: ov=%b fwd1=%b fwd0=%b v0=%h required 1 0 1 %h",
               out_valid, out_vs1_fwd, out_v0_fwd, out_v0_data, model_data(e0b));
    end
    retire_uop();
    idle_inputs();
  endtask

  task automatic test_flush();
    int lat;
    uop_vs1_idx = 1; uop_vs1_vld = 1; vs1_wait = 1; uop_valid = 1;
    step();
    uop_valid = 0;
    step();
    flush = 1;
    step();
    flush = 0;
    checks++;
    if (out_valid !== 1'b0 || uop_ready !== 1'b1 || hold_vs1_vld !== 1'b0 || stall_cycles !== '0) begin
      failures++;
      $display("FAIL flush_hold: ov=%b ready=%b hvld=%b stall=%0d required 0 1 0 0",
               out_valid, uop_ready, hold_vs1_vld, stall_cycles);
    end
    vs1_wait = 0;
    flush = 1; uop_valid = 1;
    step();
    flush = 0; uop_valid = 0;
    checks++;
    if (hold_vs1_vld !== 1'b0 || uop_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_nocapture: hvld=%b ready=%b ov=%b required 0 1 0", hold_vs1_vld, uop_ready, out_valid);
    end
    offer(0, lat);
    flush = 1;
    step();
    flush = 0;
    checks++;
    if (lat !== 2 || out_valid !== 1'b0 || uop_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_issue: lat=%0d ov=%b ready=%b required 2 0 1", lat, out_valid, uop_ready);
    end
    idle_inputs();
  endtask

  task automatic test_masked_and_reset();
    int lat;
    randomize_rob();
    rob_head = 0; v0_hit = 8'b0000_0100;
    uop_vm = 0; uop_vs1_vld = 0; uop_vs2_vld = 0;
    offer(0, lat);
    checks++;
    if (lat !== 2 || out_v0_fwd !== 1'b1 || out_v0_data !== rob_data[2] ||
        out_vs1_fwd !== 1'b0 || out_vs2_fwd !== 1'b0) begin
      failures++;
      $display("FAIL masked_v0: lat=%0d fwd=%b%b%b v0=%h required 2 001 %h",
               lat, out_vs1_fwd, out_vs2_fwd, out_v0_fwd, out_v0_data, rob_data[2]);
    end
    retire_uop();
    uop_vs2_vld = 1; uop_valid = 1; vs2_wait = 1;
    step();
    uop_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    vs2_wait = 0;
    checks++;
    if (out_valid !== 1'b0 || stall_cycles !== '0 || hold_vs2_vld !== 1'b0 || hold_vm !== 1'b1 ||
        uop_ready !== 1'b1 || out_v0_fwd !== 1'b0 || out_v0_data !== '0) begin
      failures++;
      $display("FAIL rst_mid_hold: ov=%b stall=%0d hvld=%b hvm=%b ready=%b fwd0=%b required 0 0 0 1 1 0",
               out_valid, stall_cycles, hold_vs2_vld, hold_vm, uop_ready, out_v0_fwd);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < D; i++) rob_data[i] = '0;
    test_reset();
    test_no_hazard();
    test_youngest_select();
    test_stall();
    test_back_to_back();
    test_flush();
    test_masked_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
